// File: rtl/uart_rx_tx.sv
// 8N1 UART receiver and transmitter with independent RX/TX state machines.
// Optional macro UART_RX_SYNC_EN adds a two-flop synchronizer on i_Rx_Serial.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | line idle; RX waits for a low sample, TX waits for i_Tx_DV
// S_START   | start bit; RX checks it at mid-bit, TX drives 0
// S_DATA    | eight data bits, LSB first
// S_STOP    | stop bit; RX validates it, TX drives 1
// S_CLEANUP | single-cycle completion (RX DV pulse / TX done pulse)
module uart_rx_tx #(
  parameter int CLKS_PER_BIT = 86
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] ONE       = TW'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_t;

  logic rx_line;

`ifdef UART_RX_SYNC_EN
  logic rx_meta;
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_line <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_line <= rx_meta;
    end
  end
`else
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) rx_line <= 1'b1;
    else          rx_line <= i_Rx_Serial;
  end
`endif

  // ---------------- receiver ----------------
  state_t        rx_state, rx_state_nxt;
  logic [TW-1:0] rx_timer, rx_timer_nxt;
  logic [2:0]    rx_idx, rx_idx_nxt;
  logic [7:0]    rx_shift, rx_shift_nxt;
  logic [7:0]    rx_byte, rx_byte_nxt;
  logic          rx_dv, rx_dv_nxt;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_state <= S_IDLE;
      rx_timer <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_dv    <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_timer <= rx_timer_nxt;
      rx_idx   <= rx_idx_nxt;
      rx_shift <= rx_shift_nxt;
      rx_byte  <= rx_byte_nxt;
      rx_dv    <= rx_dv_nxt;
    end
  end

  // All RX sample points are timed from the start-bit midpoint.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_timer_nxt = rx_timer;
    rx_idx_nxt   = rx_idx;
    rx_shift_nxt = rx_shift;
    rx_byte_nxt  = rx_byte;
    rx_dv_nxt    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_idx_nxt = '0;
        if (!rx_line) begin
          rx_state_nxt = S_START;
          rx_timer_nxt = HALF_LOAD;
        end
      end
      S_START: begin
        if (rx_timer == '0) begin
          if (!rx_line) begin
            rx_state_nxt = S_DATA;
            rx_timer_nxt = BIT_LOAD;
          end else begin
            rx_state_nxt = S_IDLE;
          end
        end else begin
          rx_timer_nxt = rx_timer - ONE;
        end
      end
      S_DATA: begin
        if (rx_timer == '0) begin
          rx_shift_nxt = {rx_line, rx_shift[7:1]};
          rx_timer_nxt = BIT_LOAD;
          if (rx_idx == 3'd7) rx_state_nxt = S_STOP;
          else                rx_idx_nxt   = rx_idx + 3'd1;
        end else begin
          rx_timer_nxt = rx_timer - ONE;
        end
      end
      S_STOP: begin
        if (rx_timer == '0) begin
          rx_state_nxt = S_CLEANUP;
          if (rx_line) begin
            rx_byte_nxt = rx_shift;
            rx_dv_nxt   = 1'b1;
          end
        end else begin
          rx_timer_nxt = rx_timer - ONE;
        end
      end
      S_CLEANUP: rx_state_nxt = S_IDLE;
      default:   rx_state_nxt = S_IDLE;
    endcase
  end

  assign o_Rx_DV   = rx_dv;
  assign o_Rx_Byte = rx_byte;

  // ---------------- transmitter ----------------
  state_t        tx_state, tx_state_nxt;
  logic [TW-1:0] tx_timer, tx_timer_nxt;
  logic [2:0]    tx_idx, tx_idx_nxt;
  logic [7:0]    tx_data, tx_data_nxt;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx_state <= S_IDLE;
      tx_timer <= '0;
      tx_idx   <= '0;
      tx_data  <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_timer <= tx_timer_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_data  <= tx_data_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_timer_nxt = tx_timer;
    tx_idx_nxt   = tx_idx;
    tx_data_nxt  = tx_data;
    o_Tx_Serial  = 1'b1;
    o_Tx_Active  = 1'b0;
    o_Tx_Done    = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_idx_nxt = '0;
        if (i_Tx_DV) begin
          tx_data_nxt  = i_Tx_Byte;
          tx_timer_nxt = BIT_LOAD;
          tx_state_nxt = S_START;
        end
      end
      S_START: begin
        o_Tx_Serial = 1'b0;
        o_Tx_Active = 1'b1;
        if (tx_timer == '0) begin
          tx_timer_nxt = BIT_LOAD;
          tx_state_nxt = S_DATA;
        end else begin
          tx_timer_nxt = tx_timer - ONE;
        end
      end
      S_DATA: begin
        o_Tx_Serial = tx_data[tx_idx];
        o_Tx_Active = 1'b1;
        if (tx_timer == '0) begin
          tx_timer_nxt = BIT_LOAD;
          if (tx_idx == 3'd7) tx_state_nxt = S_STOP;
          else                tx_idx_nxt   = tx_idx + 3'd1;
        end else begin
          tx_timer_nxt = tx_timer - ONE;
        end
      end
      S_STOP: begin
        o_Tx_Active = 1'b1;
        if (tx_timer == '0) tx_state_nxt = S_CLEANUP;
        else                tx_timer_nxt = tx_timer - ONE;
      end
      S_CLEANUP: begin
        o_Tx_Done    = 1'b1;
        tx_state_nxt = S_IDLE;
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Scoreboard bench for uart_rx_tx: stimulus pushes expected bytes, monitors
// decode DV/Done events and the TX waveform and compare against the queues.
module tb_uart_rx_tx;

  localparam int CPB = 86;

  logic       i_Clock = 1'b0;
  logic       i_Rst_n;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;

  uart_rx_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_Rx_Serial(i_Rx_Serial),
    .o_Rx_DV    (o_Rx_DV),
    .o_Rx_Byte  (o_Rx_Byte),
    .i_Tx_DV    (i_Tx_DV),
    .i_Tx_Byte  (i_Tx_Byte),
    .o_Tx_Active(o_Tx_Active),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Done  (o_Tx_Done)
  );

  always #50 i_Clock = ~i_Clock;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  int rx_dv_cnt = 0;
  int done_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endfunction

  // RX monitor
  always @(negedge i_Clock) begin
    if (i_Rst_n && o_Rx_DV) begin
      rx_dv_cnt++;
      if (exp_rx.size() == 0) begin
        checks++;
        $display("FAIL rx_unexpected_dv: got byte %0h, required no DV", o_Rx_Byte);
      end else begin
        check("rx_byte", o_Rx_Byte, exp_rx.pop_front());
      end
    end
  end

  // TX monitor: checks every cycle of the frame against the queued byte
  logic       tracking = 1'b0;
  int         tcnt;
  int         wave_err;
  logic [9:0] frame;

  always @(negedge i_Clock) begin
    if (!i_Rst_n) begin
      tracking = 1'b0;
    end else begin
      if (o_Tx_Active && !tracking) begin
        tracking = 1'b1;
        tcnt     = 0;
        wave_err = 0;
        if (exp_tx.size() == 0) begin
          checks++;
          $display("FAIL tx_unexpected_frame: got active frame, required idle");
          frame = 10'h3FF;
        end else begin
          frame = {1'b1, exp_tx[0], 1'b0};
        end
      end
      if (tracking) begin
        if (o_Tx_Done) begin
          done_cnt++;
          check("tx_frame_len", tcnt, 10 * CPB);
          check("tx_wave_errs", wave_err, 0);
          check("tx_active_at_done", o_Tx_Active, 1'b0);
          check("tx_serial_at_done", o_Tx_Serial, 1'b1);
          if (exp_tx.size() != 0) void'(exp_tx.pop_front());
          tracking = 1'b0;
        end else begin
          if ((tcnt / CPB) > 9 || o_Tx_Serial !== frame[tcnt / CPB] || o_Tx_Active !== 1'b1)
            wave_err++;
          tcnt++;
          if (tcnt > 12 * CPB) begin
            checks++;
            $display("FAIL tx_timeout: got %0d cycles without done, required %0d", tcnt, 10 * CPB);
            tracking = 1'b0;
          end
        end
      end else if (o_Tx_Done) begin
        done_cnt++;
        checks++;
        $display("FAIL tx_unexpected_done: got done pulse, required none");
      end
    end
  end

  task automatic tx_send(input logic [7:0] b);
    @(negedge i_Clock);
    i_Tx_DV   = 1'b1;
    i_Tx_Byte = b;
    exp_tx.push_back(b);
    @(negedge i_Clock);
    i_Tx_DV = 1'b0;
  endtask

  task automatic wait_tx_done(input int budget);
    int base;
    base = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_Clock);
      if (done_cnt != base) break;
    end
    check("tx_done_count", done_cnt - base, 1);
  endtask

  task automatic rx_bits(input logic [7:0] b, input int start_len, input logic stop_bit);
    @(negedge i_Clock);
    i_Rx_Serial = 1'b0;
    repeat (start_len) @(negedge i_Clock);
    for (int k = 0; k < 8; k++) begin
      i_Rx_Serial = b[k];
      repeat (CPB) @(negedge i_Clock);
    end
    i_Rx_Serial = stop_bit;
    repeat (CPB) @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
    repeat (150) @(negedge i_Clock);
  endtask

  initial begin
    int base;
    i_Rst_n     = 1'b0;
    i_Rx_Serial = 1'b1;
    i_Tx_DV     = 1'b0;
    i_Tx_Byte   = 8'h00;
    repeat (3) @(negedge i_Clock);
    check("rst_tx_serial", o_Tx_Serial, 1'b1);
    check("rst_tx_active", o_Tx_Active, 1'b0);
    check("rst_tx_done", o_Tx_Done, 1'b0);
    check("rst_rx_dv", o_Rx_DV, 1'b0);
    check("rst_rx_byte", o_Rx_Byte, 8'h00);
    @(negedge i_Clock);
    i_Rst_n = 1'b1;
    repeat (5) @(negedge i_Clock);

    // transmit 0xAB
    tx_send(8'hAB);
    wait_tx_done(1000);
    repeat (10) @(negedge i_Clock);

    // stretched start bit (96 cycles), 0x3D
    exp_rx.push_back(8'h3D);
    rx_bits(8'h3D, 96, 1'b1);
    check("rx_dv_count_3d", rx_dv_cnt, 1);
    check("rx_hold_3d", o_Rx_Byte, 8'h3D);

    // 20-cycle glitch
    @(negedge i_Clock);
    i_Rx_Serial = 1'b0;
    repeat (20) @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
    repeat (200) @(negedge i_Clock);
    check("glitch_dv_count", rx_dv_cnt, 1);
    check("glitch_byte_held", o_Rx_Byte, 8'h3D);

    // framing error then good byte
    rx_bits(8'h55, CPB, 1'b0);
    check("frame_err_dv_count", rx_dv_cnt, 1);
    check("frame_err_byte_held", o_Rx_Byte, 8'h3D);
    exp_rx.push_back(8'hA5);
    rx_bits(8'hA5, CPB, 1'b1);
    check("rx_dv_count_a5", rx_dv_cnt, 2);
    check("rx_hold_a5", o_Rx_Byte, 8'hA5);

    // simultaneous TX and RX
    fork
      begin
        tx_send(8'h5A);
        wait_tx_done(1000);
      end
      begin
        exp_rx.push_back(8'hC3);
        rx_bits(8'hC3, CPB, 1'b1);
      end
    join
    check("rx_dv_count_c3", rx_dv_cnt, 3);

    // request mid-frame is ignored
    base = done_cnt;
    tx_send(8'hAB);
    repeat (300) @(negedge i_Clock);
    i_Tx_DV   = 1'b1;
    i_Tx_Byte = 8'h12;
    @(negedge i_Clock);
    i_Tx_DV = 1'b0;
    wait_tx_done(1000);
    repeat (1000) @(negedge i_Clock);
    check("ignored_req_done_total", done_cnt - base, 1);
    check("ignored_req_idle", o_Tx_Active, 1'b0);

    // reset during TX DATA (bit 2 of 0xF0 is 0)
    base = done_cnt;
    tx_send(8'hF0);
    repeat (300) @(negedge i_Clock);
    check("abort_pre_serial", o_Tx_Serial, 1'b0);
    i_Rst_n = 1'b0;
    #1;
    check("abort_tx_serial", o_Tx_Serial, 1'b1);
    check("abort_tx_active", o_Tx_Active, 1'b0);
    check("abort_tx_done", o_Tx_Done, 1'b0);
    check("abort_rx_byte", o_Rx_Byte, 8'h00);
    exp_tx.delete();
    repeat (3) @(negedge i_Clock);
    i_Rst_n = 1'b1;
    repeat (1000) @(negedge i_Clock);
    check("abort_no_done", done_cnt - base, 0);
    check("abort_idle_serial", o_Tx_Serial, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_tx.md
UART_RX_TX -- requirements
Module: uart_rx_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 86, means clock cycles per serial bit (86 gives 115200 baud at a 10 MHz clock); legal range is 4..65535.
REQ-002 Port i_Clock, input, 1 bit: single system clock; all logic is rising-edge triggered.
REQ-003 Port i_Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port i_Rx_Serial, input, 1 bit: serial receive line, idle high.
REQ-005 Port o_Rx_DV, output, 1 bit: one-cycle pulse when a valid byte has been received.
REQ-006 Port o_Rx_Byte, output, 8 bits: last valid received byte, held until the next valid byte.
REQ-007 Port i_Tx_DV, input, 1 bit: transmit request, sampled in TX IDLE.
REQ-008 Port i_Tx_Byte, input, 8 bits: byte to transmit, captured when the request is accepted.
REQ-009 Port o_Tx_Active, output, 1 bit: high while a TX frame is in progress.
REQ-010 Port o_Tx_Serial, output, 1 bit: serial transmit line, idle high.
REQ-011 Port o_Tx_Done, output, 1 bit: one-cycle pulse at TX frame completion.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1, no parity.
REQ-013 TX FSM states SHALL be IDLE, START, DATA, STOP, CLEANUP; RX and TX SHALL be fully independent.
REQ-014 TX IDLE: when i_Tx_DV=1 on a clock edge, latch i_Tx_Byte and go to START; o_Tx_Serial=1 and o_Tx_Active=0 while idle.
REQ-015 TX START/DATA/STOP: drive 0, then bits [0..7], then 1, each for exactly CLKS_PER_BIT cycles, starting the cycle after acceptance.
REQ-016 TX: o_Tx_Active=1 from the first START cycle through the last STOP cycle.
REQ-017 TX STOP to CLEANUP: o_Tx_Done=1 for exactly one cycle, o_Tx_Active=0, line stays 1.
REQ-018 TX return to IDLE: occurs the next cycle; i_Tx_DV asserted outside IDLE is ignored, not queued.
REQ-019 RX FSM states SHALL be IDLE, START, DATA, STOP, CLEANUP.
REQ-020 RX IDLE: a sampled 0 on the line enters START and clears the bit counter.
REQ-021 RX START: at CLKS_PER_BIT/2 (integer division) cycles, resample the line; if 0 go to DATA, else return to IDLE as a glitch with no output change.
REQ-022 RX DATA: sample each data bit CLKS_PER_BIT cycles after the previous sample (mid-bit), shifting LSB first into a working register.
REQ-023 RX STOP: sample CLKS_PER_BIT cycles after the bit-7 sample; if 1, update o_Rx_Byte and pulse o_Rx_DV for one cycle; if 0 (framing error), discard the byte with no DV and o_Rx_Byte unchanged.
REQ-024 RX CLEANUP: lasts one cycle, then IDLE; a new start edge is recognised from IDLE only.
REQ-025 Timing tolerance: RX SHALL receive correctly when the start bit is stretched by up to CLKS_PER_BIT/4 cycles, because it samples relative to the start-bit midpoint.
REQ-026 Counters SHALL be wide enough for CLKS_PER_BIT-1; no counter wraps within a bit.

Reset
REQ-027 While i_Rst_n=0, and asynchronously on assertion: both FSMs go to IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Rx_DV=0, o_Rx_Byte=8'h00, all counters are cleared.
REQ-028 Reset mid-frame SHALL abort the frame; no Done or DV pulse is produced for the aborted frame.
REQ-029 Operation SHALL resume on the first rising edge after deassertion.

Configuration
REQ-030 Macro UART_RX_SYNC_EN: when defined, i_Rx_Serial passes through a two-flop synchronizer reset to 1, so all RX timing shifts by two cycles.
REQ-031 When UART_RX_SYNC_EN is undefined, i_Rx_Serial feeds a single input register (one cycle delay) and the rest of the behaviour is identical.

Verification
REQ-032 Transmit test: with a 100 ns clock and CLKS_PER_BIT=86, pulse i_Tx_DV one cycle with 8'hAB -> o_Tx_Serial reads 0,1,1,0,1,0,1,0,1,1 per 86-cycle bit, o_Tx_Done pulses once 860 cycles after the start bit begins, and o_Tx_Active falls with it.
REQ-033 Stretched-start receive test: drive 8'h3D with a 9600 ns start bit and 8600 ns data and stop bits -> exactly one o_Rx_DV pulse, o_Rx_Byte=8'h3D.
REQ-034 Glitch test: drive i_Rx_Serial low for 20 cycles, then high -> no o_Rx_DV, o_Rx_Byte unchanged, RX back in IDLE.
REQ-035 Framing-error test: send 8'h55 with the stop bit 0 -> no o_Rx_DV, o_Rx_Byte keeps its previous value; a following good 8'hA5 is received correctly.
REQ-036 Ignored-request test: assert i_Tx_DV with 8'h12 mid-frame of 8'hAB -> only 8'hAB is sent and one o_Tx_Done pulse occurs.
REQ-037 Reset-abort test: assert i_Rst_n=0 during TX DATA -> o_Tx_Serial=1 immediately, with no o_Tx_Done pulse.
